// File: rtl/crash_course_cpu_pkg.sv
// crash_course_cpu_pkg
//   Shared definitions for the crash-course CPU program loader:
//   opcode enumeration, instruction-word field positions, the halt word
//   and the loader FSM state type.
//   Optional feature macro: CRASH_COURSE_LOADER_AUTO_HALT_EN (used by the
//   loader, not by this package).
package crash_course_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP        = 4'h0,
    OP_ADD        = 4'h1,
    OP_SUB        = 4'h2,
    OP_AND        = 4'h3,
    OP_OR         = 4'h4,
    OP_XOR        = 4'h5,
    OP_NOT        = 4'h6,
    OP_SHL        = 4'h7,
    OP_SHR        = 4'h8,
    OP_CMP        = 4'h9,
    OP_LOAD       = 4'hA,
    OP_LOAD_IMM   = 4'hB,
    OP_RESERVED_C = 4'hC,
    OP_HALT       = 4'hD,
    OP_JUMP       = 4'hE,
    OP_BRANCH     = 4'hF
  } opcode_e;

  // Field positions inside the 16-bit instruction word
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned REG_A_MSB  = 11;
  localparam int unsigned REG_A_LSB  = 8;
  localparam int unsigned REG_B_MSB  = 7;
  localparam int unsigned REG_B_LSB  = 4;
  localparam int unsigned REG_C_MSB  = 3;
  localparam int unsigned REG_C_LSB  = 0;
  localparam int unsigned IMM_MSB    = 7;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [15:0] HALT_WORD = 16'hD000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_APPEND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/crash_course_cpu_instruction_packer.sv
// crash_course_cpu_instruction_packer
//   Combinational encoder: decoded fields -> 16-bit instruction word.
//   Ports:
//     opcode, reg_a, reg_b, reg_c (4 bits each), immediate (8 bits) : fields
//     word    : packed instruction
//     illegal : opcode is the reserved value C
module crash_course_cpu_instruction_packer
  import crash_course_cpu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  reg_a,
  input  logic [3:0]  reg_b,
  input  logic [3:0]  reg_c,
  input  logic [7:0]  immediate,
  output logic [15:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPCODE_MSB:OPCODE_LSB] = opcode;
    case (opcode_e'(opcode))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR, OP_CMP: begin
        word[REG_A_MSB:REG_A_LSB] = reg_a;
        word[REG_B_MSB:REG_B_LSB] = reg_b;
        word[REG_C_MSB:REG_C_LSB] = reg_c;
      end
      OP_LOAD, OP_LOAD_IMM, OP_JUMP: begin
        word[REG_A_MSB:REG_A_LSB] = reg_a;
        word[IMM_MSB:IMM_LSB]     = immediate;
      end
      OP_BRANCH: begin
        // Top bit of the A field is forced to zero; only a 3-bit condition exists
        word[REG_A_MSB]               = 1'b0;
        word[REG_A_MSB-1:REG_A_LSB]   = reg_a[2:0];
        word[IMM_MSB:IMM_LSB]         = immediate;
      end
      OP_RESERVED_C: illegal = 1'b1;
      default: ;  // NOP and HALT carry no operands
    endcase
  end

endmodule

// File: rtl/crash_course_cpu_program_loader.sv
// crash_course_cpu_program_loader
//   Accepts decoded instruction fields over valid/ready, packs them and
//   writes them sequentially into instruction memory from BASE_ADDR.
//   Optional feature macro: CRASH_COURSE_LOADER_AUTO_HALT_EN -- when defined,
//   a program whose last instruction is not HALT gets a HALT word appended.
//   Ports:
//     clk, rst (async, active-high), start
//     in_valid/in_ready, in_opcode, in_reg_a/b/c, in_immediate, in_last
//     mem_write_enable/addr/data : registered memory write port
//     busy (LOAD/APPEND), done (DONE), error (sticky), word_count
module crash_course_cpu_program_loader
  import crash_course_cpu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_reg_a,
  input  logic [3:0]            in_reg_b,
  input  logic [3:0]            in_reg_c,
  input  logic [7:0]            in_immediate,
  input  logic                  in_last,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [15:0]           mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state, state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  error_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  logic [15:0] packed_word;
  logic        packed_illegal;
  logic        count_full;
  logic        load_start, write_word, write_halt, raise_error;

  crash_course_cpu_instruction_packer u_packer (
    .opcode    (in_opcode),
    .reg_a     (in_reg_a),
    .reg_b     (in_reg_b),
    .reg_c     (in_reg_c),
    .immediate (in_immediate),
    .word      (packed_word),
    .illegal   (packed_illegal)
  );

  assign count_full = (count == FULL_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_start  = 1'b0;
    write_word  = 1'b0;
    write_halt  = 1'b0;
    raise_error = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_LOAD;
          load_start = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (packed_illegal || count_full) begin
            raise_error = 1'b1;
            state_next  = ST_DONE;
          end else begin
            write_word = 1'b1;
            if (in_last) begin
`ifdef CRASH_COURSE_LOADER_AUTO_HALT_EN
              state_next = (opcode_e'(in_opcode) == OP_HALT) ? ST_DONE : ST_APPEND;
`else
              state_next = ST_DONE;
`endif
            end
          end
        end
      end
`ifdef CRASH_COURSE_LOADER_AUTO_HALT_EN
      ST_APPEND: begin
        if (count_full) raise_error = 1'b1;
        else            write_halt  = 1'b1;
        state_next = ST_DONE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= BASE_ADDR;
      count   <= '0;
      error_q <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= write_word | write_halt;
      if (load_start) begin
        addr    <= BASE_ADDR;
        count   <= '0;
        error_q <= 1'b0;
      end
      if (write_word || write_halt) begin
        wr_addr <= addr;
        wr_data <= write_halt ? HALT_WORD : packed_word;
        addr    <= addr + ADDR_WIDTH'(1);
        count   <= count + (ADDR_WIDTH+1)'(1);
      end
      if (raise_error) error_q <= 1'b1;
    end
  end

  assign in_ready         = (state == ST_LOAD);
  assign busy             = (state == ST_LOAD) || (state == ST_APPEND);
  assign done             = (state == ST_DONE);
  assign error            = error_q;
  assign word_count       = count;
  assign mem_write_enable = wr_en;
  assign mem_write_addr   = wr_addr;
  assign mem_write_data   = wr_data;

endmodule

// File: tb/tb_crash_course_cpu_program_loader.sv
module tb_crash_course_cpu_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, s_start = 1'b0;
  logic        in_valid = 1'b0, s_valid = 1'b0;
  logic [3:0]  in_opcode = '0, in_reg_a = '0, in_reg_b = '0, in_reg_c = '0;
  logic [7:0]  in_immediate = '0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_write_enable, busy, done, error;
  logic [7:0]  mem_write_addr;
  logic [15:0] mem_write_data;
  logic [8:0]  word_count;

  logic        s_in_ready, s_we, s_busy, s_done, s_error;
  logic [1:0]  s_addr;
  logic [15:0] s_data;
  logic [2:0]  s_word_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] cap_q[$];

  always #5 clk = ~clk;

  crash_course_cpu_program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
    .in_immediate(in_immediate), .in_last(in_last),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  crash_course_cpu_program_loader #(.ADDR_WIDTH(2), .BASE_ADDR(2'd0)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
    .in_immediate(in_immediate), .in_last(in_last),
    .mem_write_enable(s_we), .mem_write_addr(s_addr),
    .mem_write_data(s_data), .busy(s_busy), .done(s_done), .error(s_error),
    .word_count(s_word_count)
  );

  always @(negedge clk)
    if (mem_write_enable === 1'b1) cap_q.push_back({mem_write_addr, mem_write_data});

  // Reference encoding written directly from the instruction formats
  function automatic logic [15:0] ref_pack(input int op, input int a, input int b,
                                           input int c, input int imm);
    int v;
    if (op >= 1 && op <= 9)                    v = op*4096 + a*256 + b*16 + c;
    else if (op == 10 || op == 11 || op == 14) v = op*4096 + a*256 + imm;
    else if (op == 15)                         v = op*4096 + (a % 8)*256 + imm;
    else                                       v = op*4096;
    return 16'(v);
  endfunction

  task automatic pulse_start(input bit sel);
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    start   = 1'b0;
  endtask

  // Present one instruction and return at the negedge after it is accepted
  task automatic send(input bit sel, input logic [3:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c,
                      input logic [7:0] imm, input logic last);
    int unsigned t;
    in_opcode = op; in_reg_a = a; in_reg_b = b; in_reg_c = c;
    in_immediate = imm; in_last = last;
    if (sel) s_valid = 1'b1; else in_valid = 1'b1;
    t = 0;
    while (((sel ? s_in_ready : in_ready) !== 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready never high (sel=%0d)", sel);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input bit sel);
    int unsigned t;
    in_valid = 1'b0;
    s_valid  = 1'b0;
    t = 0;
    while (((sel ? s_done : done) !== 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_bad++;
      $display("FAIL done_timeout done never rose (sel=%0d)", sel);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, mem_write_enable, busy, done, error} !== 5'b0 ||
        mem_write_addr !== 8'h00 || mem_write_data !== 16'h0000 || word_count !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d exp all 0",
               in_ready, mem_write_enable, busy, done, error, mem_write_addr, mem_write_data, word_count);
    end
    n_cmp++;
    if ({s_in_ready, s_we, s_busy, s_done, s_error} !== 5'b0 || s_word_count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_small got rdy=%b we=%b busy=%b done=%b err=%b cnt=%0d exp all 0",
               s_in_ready, s_we, s_busy, s_done, s_error, s_word_count);
    end
  endtask

  task automatic test_add();
    pulse_start(0);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL start_busy got busy=%b rdy=%b exp 1 1", busy, in_ready);
    end
    send(0, 4'h1, 4'h3, 4'h4, 4'h5, 8'h00, 1'b1);
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_addr !== 8'h00 || mem_write_data !== 16'h1345) begin
      n_bad++;
      $display("FAIL add_write got we=%b addr=%h data=%h exp 1 00 1345",
               mem_write_enable, mem_write_addr, mem_write_data);
    end
    wait_done(0);
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    send(0, 4'hB, 4'h2, 4'h0, 4'h0, 8'h7F, 1'b0);
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_addr !== 8'h00 || mem_write_data !== 16'hB27F) begin
      n_bad++;
      $display("FAIL b2b_first got we=%b addr=%h data=%h exp 1 00 b27f",
               mem_write_enable, mem_write_addr, mem_write_data);
    end
    send(0, 4'hF, 4'hB, 4'h0, 4'h0, 8'h10, 1'b1);
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_addr !== 8'h01 || mem_write_data !== 16'hF310) begin
      n_bad++;
      $display("FAIL b2b_second got we=%b addr=%h data=%h exp 1 01 f310",
               mem_write_enable, mem_write_addr, mem_write_data);
    end
    n_cmp++;
    if (word_count !== 9'd2) begin
      n_bad++; $display("FAIL b2b_count got=%0d exp=2", word_count);
    end
`ifndef CRASH_COURSE_LOADER_AUTO_HALT_EN
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done got done=%b busy=%b exp 1 0", done, busy);
    end
`endif
    wait_done(0);
  endtask

  task automatic test_last_append();
    pulse_start(0);
    send(0, 4'h1, 4'h1, 4'h2, 4'h3, 8'h00, 1'b1);
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_data !== 16'h1123 || mem_write_addr !== 8'h00) begin
      n_bad++; $display("FAIL last_write got we=%b addr=%h data=%h exp 1 00 1123",
                        mem_write_enable, mem_write_addr, mem_write_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
`ifdef CRASH_COURSE_LOADER_AUTO_HALT_EN
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_addr !== 8'h01 || mem_write_data !== 16'hD000 ||
        word_count !== 9'd2 || done !== 1'b1) begin
      n_bad++; $display("FAIL append_halt got we=%b addr=%h data=%h cnt=%0d done=%b exp 1 01 d000 2 1",
                        mem_write_enable, mem_write_addr, mem_write_data, word_count, done);
    end
    pulse_start(0);
    send(0, 4'hD, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write_enable !== 1'b0 || word_count !== 9'd1 || done !== 1'b1) begin
      n_bad++; $display("FAIL halt_no_append got we=%b cnt=%0d done=%b exp 0 1 1",
                        mem_write_enable, word_count, done);
    end
`else
    n_cmp++;
    if (mem_write_enable !== 1'b0 || word_count !== 9'd1 || done !== 1'b1) begin
      n_bad++; $display("FAIL no_append got we=%b cnt=%0d done=%b exp 0 1 1",
                        mem_write_enable, word_count, done);
    end
`endif
  endtask

  task automatic test_illegal();
    pulse_start(0);
    send(0, 4'h2, 4'h1, 4'h2, 4'h3, 8'h00, 1'b0);
    send(0, 4'hC, 4'h1, 4'h1, 4'h1, 8'hAA, 1'b0);
    n_cmp++;
    if (mem_write_enable !== 1'b0 || error !== 1'b1 || done !== 1'b1 ||
        in_ready !== 1'b0 || word_count !== 9'd1) begin
      n_bad++; $display("FAIL illegal_op got we=%b err=%b done=%b rdy=%b cnt=%0d exp 0 1 1 0 1",
                        mem_write_enable, error, done, in_ready, word_count);
    end
    in_valid = 1'b0;
    pulse_start(0);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1 || word_count !== 9'd0 || done !== 1'b0) begin
      n_bad++; $display("FAIL restart_clears got err=%b busy=%b cnt=%0d done=%b exp 0 1 0 0",
                        error, busy, word_count, done);
    end
    send(0, 4'hD, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1);
    wait_done(0);
  endtask

  task automatic test_overflow();
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      send(1, 4'h2, 4'(i), 4'h1, 4'h2, 8'h00, 1'b0);
      n_cmp++;
      if (s_we !== 1'b1 || s_addr !== 2'(i) || s_data !== ref_pack(2, i, 1, 2, 0)) begin
        n_bad++; $display("FAIL ovf_write%0d got we=%b addr=%0d data=%h exp 1 %0d %h",
                          i, s_we, s_addr, s_data, i, ref_pack(2, i, 1, 2, 0));
      end
    end
    send(1, 4'h2, 4'h7, 4'h1, 4'h2, 8'h00, 1'b1);
    n_cmp++;
    if (s_we !== 1'b0 || s_error !== 1'b1 || s_done !== 1'b1 || s_word_count !== 3'd4) begin
      n_bad++; $display("FAIL ovf_fifth got we=%b err=%b done=%b cnt=%0d exp 0 1 1 4",
                        s_we, s_error, s_done, s_word_count);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_start(0);
    in_opcode = 4'h2; in_reg_a = 4'h5; in_reg_b = 4'h6; in_reg_c = 4'h7; in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, mem_write_enable, busy, done, error} !== 5'b0 ||
        mem_write_addr !== 8'h00 || mem_write_data !== 16'h0000 || word_count !== 9'd0) begin
      n_bad++; $display("FAIL reset_mid got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d exp all 0",
                        in_ready, mem_write_enable, busy, done, error, mem_write_addr, mem_write_data, word_count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write_enable !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle got we=%b busy=%b exp 0 0", mem_write_enable, busy);
    end
    pulse_start(0);
    send(0, 4'h1, 4'h3, 4'h4, 4'h5, 8'h00, 1'b1);
    n_cmp++;
    if (mem_write_enable !== 1'b1 || mem_write_addr !== 8'h00 || mem_write_data !== 16'h1345) begin
      n_bad++; $display("FAIL reset_restart got we=%b addr=%h data=%h exp 1 00 1345",
                        mem_write_enable, mem_write_addr, mem_write_data);
    end
    wait_done(0);
  endtask

  task automatic test_random();
    logic [23:0] exp_q[$];
    logic [3:0]  op, a, b, c;
    logic [7:0]  imm;
    logic        exp_err;
    int unsigned n;
    for (int s = 0; s < 8; s++) begin
      pulse_start(0);
      exp_q.delete();
      cap_q.delete();
      exp_err = 1'b0;
      n = $urandom_range(1, 12);
      for (int i = 0; i < int'(n); i++) begin
        op = 4'($urandom_range(0, 15));
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); imm = 8'($urandom);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(0, op, a, b, c, imm, i == int'(n) - 1);
        if (op == 4'hC) begin
          exp_err = 1'b1;
          break;
        end
        exp_q.push_back({8'(exp_q.size()), ref_pack(int'(op), int'(a), int'(b), int'(c), int'(imm))});
`ifdef CRASH_COURSE_LOADER_AUTO_HALT_EN
        if (i == int'(n) - 1 && op != 4'hD) exp_q.push_back({8'(exp_q.size()), 16'hD000});
`endif
      end
      wait_done(0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (cap_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", s, cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        n_cmp++;
        if (cap_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand%0d_write%0d got addr/data=%h exp=%h", s, i, cap_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (error !== exp_err || word_count !== 9'(exp_q.size())) begin
        n_bad++; $display("FAIL rand%0d_status got err=%b cnt=%0d exp %b %0d",
                          s, error, word_count, exp_err, exp_q.size());
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_back_to_back();
    test_last_append();
    test_illegal();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crash_course_cpu_program_loader.md
# crash_course_cpu_program_loader

Streaming instruction encoder and program loader for the crash-course CPU. It accepts decoded instruction fields over a valid/ready interface and packs each one into the 16-bit CPU instruction word. The packed words are written sequentially into instruction memory. It sits between the host/test stimulus source and the instruction RAM that the CPU fetch/decode path reads.

## Interface
- `ADDR_WIDTH`, 8, instruction memory address width.
- `BASE_ADDR`, 0, first address written after `start`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a load session; honoured only in IDLE or DONE.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: loader accepts fields this cycle.
- `in_opcode` in 4: instruction opcode.
- `in_reg_a` in 4: destination/A register; bits [2:0] are the branch condition for opcode F.
- `in_reg_b` in 4: B register.
- `in_reg_c` in 4: C register.
- `in_immediate` in 8: immediate / jump-branch target.
- `in_last` in 1: final instruction of the program.
- `mem_write_enable` out 1: write strobe.
- `mem_write_addr` out ADDR_WIDTH: write address.
- `mem_write_data` out 16: packed instruction.
- `busy` out 1: high in LOAD/APPEND.
- `done` out 1: high in DONE.
- `error` out 1: sticky fault flag.
- `word_count` out ADDR_WIDTH+1: words written this session.

## Operation
- Packing by opcode:
  - 1–9: {op, a, b, c}.
  - A, B, E: {op, a, imm}.
  - F: {op, 1'b0, a[2:0], imm}.
  - 0 and D: {op, 12'h000}.
- Opcode C is reserved and illegal.
- FSM states: IDLE, LOAD, APPEND (macro only), DONE.
- IDLE→LOAD on `start`: address ← BASE_ADDR, `word_count` ← 0, `error` ← 0.
- In LOAD, `in_ready` = 1. A handshake (`in_valid` & `in_ready`) with a legal opcode registers one write and increments the address and `word_count`.
- Handshake with `in_last` → DONE (or APPEND, see Configuration).
- Illegal opcode handshake: no write, `error` ← 1, → DONE.
- Overflow: a handshake when `word_count` == 2**ADDR_WIDTH produces no write, sets `error` ← 1, → DONE.
- Address arithmetic wraps modulo 2**ADDR_WIDTH. `word_count` is the overflow guard, so no address is ever written twice.
- In DONE, `start` restarts straight to LOAD with counters cleared. All other input is ignored (`in_ready` = 0).
- `start` during LOAD/APPEND is ignored.
- Reset values: all outputs 0, state IDLE, address BASE_ADDR.
- Reset mid-session aborts immediately. Memory already written is left as is, and the in-flight registered write is dropped.

## Timing
- Handshake at edge N → `mem_write_enable`/addr/data valid for exactly the cycle after edge N. The strobe is high for one cycle per accepted word.
- Throughput: one instruction per cycle, no bubbles in LOAD.
- `in_ready` depends only on registered state (no combinational path from `in_valid`).
- `done` rises in the same cycle the final write strobe is high. On error, `done` rises the cycle after the offending handshake.
- `busy` and `done` are never simultaneously high.

## Configuration
- `CRASH_COURSE_LOADER_AUTO_HALT_EN` defined:
  - On an `in_last` handshake whose opcode ≠ D, the FSM goes to APPEND.
  - APPEND writes 16'hD000 at the next address one cycle after the last word, then → DONE; `word_count` includes it.
  - If the memory is full at APPEND, `error` ← 1 and no write.
- Undefined: APPEND does not exist and `in_last` → DONE directly.

## Structure
- Shared package `crash_course_cpu_pkg`:
  - Opcode enum (NOP…BRANCH, RESERVED_C).
  - Field bit-position localparams.
  - HALT_WORD constant (16'hD000).
  - FSM state typedef.
- Sub-module `crash_course_cpu_instruction_packer`: combinational fields→16-bit word plus `illegal` flag. The loader owns the FSM, counters and write register.

## Test plan
- Add, a=3, b=4, c=5 at BASE_ADDR=0 → one strobe, addr 0, data 16'h1345.
- Back-to-back, `in_valid` held: LoadImm a=2 imm=8'h7F, then Branch a=4'hB imm=8'h10 with `in_last` → data 16'hB27F @0 and 16'hF310 @1 on consecutive cycles; `done` = 1; `word_count` = 2.
- Opcode C mid-stream after one legal word → no second strobe, `error` = 1, `done` = 1, `in_ready` = 0; `start` then clears `error`.
- ADDR_WIDTH=2: five instructions → four writes at addresses 0–3; the fifth handshake sets `error`, no write.
- With the macro: last = Add 16'h1123 → next cycle write 16'hD000 at the following address; `word_count` = 2. If the last instruction is Halt, no append.
- `rst` asserted the cycle after a handshake → no write strobe, all outputs 0; the next `start` restarts at BASE_ADDR.
